// File: rtl/bit_interleaver.sv
// bit_interleaver: 802.11a TX block interleaver with ping-pong banks, 1 bit/clock sustained.
module bit_interleaver #(
  parameter int N_CBPS = 48,
  parameter int N_BPSC = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic In_Data,
  input  logic In_Valid,
  output logic In_Ready,
  output logic Out_Data,
  output logic Out_Valid,
  input  logic Out_Ready,
  output logic Out_Last
);
  localparam int AW = $clog2(N_CBPS);
  localparam int S = (N_BPSC / 2 > 1) ? N_BPSC / 2 : 1;
  localparam logic [AW-1:0] LAST = AW'(N_CBPS - 1);
  function automatic int jfun(input int k);
    int i;
    i = (N_CBPS / 16) * (k % 16) + k / 16;
    return S * (i / S) + (i + N_CBPS - (16 * i) / N_CBPS) % S;
  endfunction
  logic [N_CBPS-1:0] mem [2];
  logic [AW-1:0] jmap [N_CBPS];
  logic [1:0] full;
  logic wb, rb;
  logic [AW-1:0] wc, rc;
  logic in_fire, out_fire;
  // write-address permutation folds to a constant table
  for (genvar g = 0; g < N_CBPS; g++) begin : g_map
    assign jmap[g] = AW'(jfun(g));
  end
  assign In_Ready = !full[wb];
  assign Out_Valid = full[rb];
  assign Out_Data = Out_Valid && mem[rb][rc];
  assign Out_Last = Out_Valid && (rc == LAST);
  assign in_fire = In_Valid && In_Ready;
  assign out_fire = Out_Valid && Out_Ready;
  always_ff @(posedge Clock) begin
    if (in_fire) mem[wb][jmap[wc]] <= In_Data;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wc <= '0;
      rc <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      full <= 2'b00;
    end else begin
      if (in_fire) begin
        wc <= (wc == LAST) ? '0 : wc + 1'b1;
        if (wc == LAST) begin
          full[wb] <= 1'b1;
          wb <= !wb;
        end
      end
      if (out_fire) begin
        rc <= (rc == LAST) ? '0 : rc + 1'b1;
        if (rc == LAST) begin
          full[rb] <= 1'b0;
          rb <= !rb;
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_interleaver.sv
// tb_bit_interleaver: scoreboard bench for the (48,1) and (192,4) interleaver configurations.
module tb_bit_interleaver;
  logic clk = 1'b0;
  logic Reset = 1'b1, In_Data = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0;
  logic [1:0] ir, od, ov, ol;
  int total = 0, bad = 0, drops = 0, sel = 0, c0 = 0;
  bit stream = 1'b0;
  logic [191:0] v, v2, e;
  always #5 clk = ~clk;
  function automatic int jref(input int k, input int nc, input int nb);
    int s, i;
    s = (nb / 2 > 1) ? nb / 2 : 1;
    i = (nc / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + nc - (16 * i) / nc) % s;
  endfunction
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one DUT per configuration; both see the same input stream and each models its own handshakes
  for (genvar d = 0; d < 2; d++) begin : m
    localparam int NC = d ? 192 : 48;
    localparam int NB = d ? 4 : 1;
    bit q[$];
    bit ib[NC];
    bit ex[NC];
    bit x;
    int ic = 0, oc = 0, nout = 0;
    logic [NC-1:0] cur = '0, last_sym = '0;
    bit_interleaver #(.N_CBPS(NC), .N_BPSC(NB)) u (
      .Clock(clk), .Reset(Reset), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(ir[d]),
      .Out_Data(od[d]), .Out_Valid(ov[d]), .Out_Ready(Out_Ready), .Out_Last(ol[d])
    );
    always @(negedge clk) begin
      if (Reset) begin
        q.delete();
        ic = 0;
        oc = 0;
      end else begin
        if (In_Valid && ir[d]) begin
          ib[ic] = In_Data;
          ic++;
          if (ic == NC) begin
            for (int k = 0; k < NC; k++) ex[jref(k, NC, NB)] = ib[k];
            for (int n = 0; n < NC; n++) q.push_back(ex[n]);
            ic = 0;
          end
        end
        if (ov[d] && Out_Ready) begin
          total++;
          assert (q.size() != 0) else begin
            bad++;
            $error("FAIL spurious_output observed=%0d expected=queued", q.size());
          end
          if (q.size() != 0) begin
            x = q.pop_front();
            chk("out_data", od[d], x);
            chk("out_last", ol[d], oc == NC - 1);
            cur[oc] = od[d];
            nout++;
            if (oc == NC - 1) begin
              last_sym = cur;
              oc = 0;
            end else oc++;
          end
        end else if (!ov[d]) begin
          chk("idle_data", od[d], 0);
          chk("idle_last", ol[d], 0);
        end
      end
    end
  end
  always @(negedge clk) if (stream && In_Valid && !ir[0]) drops++;
  function automatic logic [191:0] rnd();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input bit b);
    int n;
    bit ok;
    n = 0;
    In_Valid = 1'b1;
    In_Data = b;
    do begin
      @(negedge clk);
      ok = ir[sel];
      step();
      n++;
    end while (!ok && n < 2000);
    if (!ok) chk("in_timeout", ok, 1);
  endtask
  task automatic send(input logic [191:0] d, input int n);
    for (int k = 0; k < n; k++) put(d[k]);
    In_Valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((m[0].q.size() != 0 || m[1].q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_timeout", m[0].q.size() + m[1].q.size(), 0);
  endtask
  initial begin
    step();
    step();
    Reset = 1'b0;
    chk("rst_ready", ir[0], 1);
    chk("rst_valid", ov[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_last", ol[0], 0);
    Out_Ready = 1'b1;
    v = '0; v[1] = 1'b1; send(v, 48); drain();
    chk("t1_k1", m[0].last_sym, 192'h8);
    v = '0; v[16] = 1'b1; send(v, 48); drain();
    chk("t2_k16", m[0].last_sym, 192'h2);
    v = '0; v[47] = 1'b1; send(v, 48); drain();
    e = '0; e[47] = 1'b1;
    chk("t2_k47", m[0].last_sym, e);
    send(rnd(), 48); drain();
    c0 = m[0].nout;
    stream = 1'b1;
    v = rnd();
    for (int k = 0; k < 47; k++) put(v[k]);
    chk("t3_pre_valid", ov[0], 0);
    put(v[47]);
    chk("t3_valid", ov[0], 1);
    v2 = rnd();
    for (int k = 0; k < 96; k++) put(v2[k]);
    In_Valid = 1'b0;
    stream = 1'b0;
    repeat (48) step();
    chk("t3_count", m[0].nout - c0, 144);
    chk("t3_done", ov[0], 0);
    chk("t3_drops", drops, 0);
    Out_Ready = 1'b0;
    send(rnd(), 96);
    v = rnd();
    In_Valid = 1'b1;
    In_Data = v[0];
    step();
    chk("t4_full", ir[0], 0);
    Out_Ready = 1'b1;
    repeat (47) step();
    chk("t4_hold", ir[0], 0);
    step();
    chk("t4_resume", ir[0], 1);
    send(v, 48); drain();
    Out_Ready = 1'b0;
    send(rnd(), 48);
    v = rnd();
    for (int k = 0; k < 10; k++) put(v[k]);
    Out_Ready = 1'b1;
    for (int k = 10; k < 20; k++) put(v[k]);
    In_Valid = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t5_valid", ov[0], 0);
    chk("t5_ready", ir[0], 1);
    chk("t5_data", od[0], 0);
    chk("t5_last", ol[0], 0);
    send(rnd(), 48); drain();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    sel = 1;
    v = '0; v[1] = 1'b1; send(v, 192); drain();
    e = '0; e[13] = 1'b1;
    chk("t6_k1", m[1].last_sym, e);
    v = '0; v[0] = 1'b1; send(v, 192); drain();
    chk("t6_k0", m[1].last_sym, 192'h1);
    send(rnd(), 192);
    send(rnd(), 192);
    drain();
    sel = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
